// File: rtl/pipe_stage_fifo_if.sv
// Valid/ready handshake bundle for pipe_stage_fifo: upstream push side and downstream pop side.
// The stage connects through the slave modport; the driving environment uses master.
interface pipe_stage_fifo_if #(
    parameter int DATA_W = 200
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline stage: DEPTH-entry FIFO with valid/ready on both sides, synchronous flush
// and a saturating back-pressure cycle counter.
module pipe_stage_fifo #(
    parameter int DATA_W = 200,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     stat_clr,
    pipe_stage_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         stall_cycles
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_count;
    logic              r_live;
    logic [CNT_W-1:0]  r_stall;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // r_live holds in_ready low until the first edge after reset release.
    assign w_in_ready  = r_live && (r_count < FULL_CNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
    assign count         = r_count;
    assign stall_cycles  = r_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register-array storage is cleared on reset as well, so no X
            // can ever reach out_data; this is cheap at small DEPTH.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_live   <= 1'b0;
            r_stall  <= '0;
        end else begin
            r_live <= 1'b1;

            // Flush kills both the held entries and any transfer in the same cycle.
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= bus.in_data;
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end

            if (stat_clr) begin
                r_stall <= '0;
            end else if (w_out_valid && !bus.out_ready && (r_stall != '1)) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end
endmodule
